// File: rtl/btn_sw_conditioner.sv
// Push-button and slide-switch input conditioner: per-channel two-flop synchronizer
// followed by a debounce FSM, with registered levels and per-button press/release pulses.
module btn_sw_conditioner #(
   parameter int NB_BTN          = 4,
   parameter int NB_SW           = 4,
   parameter int NB_DEBOUNCE     = 20,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic              CLK100MHZ,
   input  logic              ck_rst,
   input  logic [NB_BTN-1:0] i_btn,
   input  logic [NB_SW-1:0]  i_sw,
   output logic [NB_BTN-1:0] o_btn,
   output logic [NB_BTN-1:0] o_btn_press,
   output logic [NB_BTN-1:0] o_btn_release,
   output logic [NB_SW-1:0]  o_sw
);

   localparam int NB_CH = NB_BTN + NB_SW;
   localparam logic [NB_DEBOUNCE-1:0] CNT_LAST = NB_DEBOUNCE'(DEBOUNCE_CYCLES - 1);
   localparam logic [NB_DEBOUNCE-1:0] CNT_ONE  = NB_DEBOUNCE'(1);

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_PEND,
      PRESSED,
      RELEASE_PEND
   } state_t;

   // Buttons occupy the low channels so the pulse logic can be gated on the index.
   logic [NB_CH-1:0] raw;
   logic [NB_CH-1:0] level;

   assign raw = {i_sw, i_btn};

   genvar gi;
   generate
      for (gi = 0; gi < NB_CH; gi++) begin : g_ch
         logic                   sync1_reg;
         logic                   sync2_reg;
         state_t                 state_reg;
         state_t                 state_next;
         logic [NB_DEBOUNCE-1:0] cnt_reg;
         logic [NB_DEBOUNCE-1:0] cnt_next;
         logic                   level_reg;

         always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
            if (!ck_rst) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
               state_reg <= RELEASED;
               cnt_reg   <= '0;
               level_reg <= 1'b0;
            end else begin
               sync1_reg <= raw[gi];
               sync2_reg <= sync1_reg;
               state_reg <= state_next;
               cnt_reg   <= cnt_next;
               level_reg <= (state_next == PRESSED) || (state_next == RELEASE_PEND);
            end
         end

         always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            case (state_reg)
               RELEASED: begin
                  if (sync2_reg) begin
                     state_next = PRESS_PEND;
                     cnt_next   = '0;
                  end
               end
               PRESS_PEND: begin
                  if (!sync2_reg)
                     state_next = RELEASED;
                  else if (cnt_reg == CNT_LAST)
                     state_next = PRESSED;
                  else
                     cnt_next = cnt_reg + CNT_ONE;
               end
               PRESSED: begin
                  if (!sync2_reg) begin
                     state_next = RELEASE_PEND;
                     cnt_next   = '0;
                  end
               end
               RELEASE_PEND: begin
                  if (sync2_reg)
                     state_next = PRESSED;
                  else if (cnt_reg == CNT_LAST)
                     state_next = RELEASED;
                  else
                     cnt_next = cnt_reg + CNT_ONE;
               end
               default: state_next = RELEASED;
            endcase
         end

         assign level[gi] = level_reg;

         // Only the pending-to-settled transitions pulse; bounce aborts stay silent.
         if (gi < NB_BTN) begin : g_pulse
            logic press_reg;
            logic release_reg;

            always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
               if (!ck_rst) begin
                  press_reg   <= 1'b0;
                  release_reg <= 1'b0;
               end else begin
                  press_reg   <= (state_reg == PRESS_PEND)   && (state_next == PRESSED);
                  release_reg <= (state_reg == RELEASE_PEND) && (state_next == RELEASED);
               end
            end

            assign o_btn_press[gi]   = press_reg;
            assign o_btn_release[gi] = release_reg;
         end
      end
   endgenerate

   assign o_btn = level[NB_BTN-1:0];
   assign o_sw  = level[NB_CH-1:NB_BTN];

endmodule

// File: tb/tb_btn_sw_conditioner.sv
// Scoreboard bench: a run-length debounce model predicts every output cycle,
// and a negedge monitor pops and compares; directed scenarios add latency checks.
`timescale 1ns/1ps
module tb_btn_sw_conditioner;

   localparam int NB  = 4;
   localparam int NS  = 4;
   localparam int NCH = NB + NS;
   localparam int D   = 8;

   logic          clk;
   logic          rst_n;
   logic [NB-1:0] i_btn;
   logic [NS-1:0] i_sw;
   logic [NB-1:0] o_btn, o_btn_press, o_btn_release;
   logic [NS-1:0] o_sw;

   btn_sw_conditioner #(
      .NB_BTN(NB), .NB_SW(NS), .NB_DEBOUNCE(20), .DEBOUNCE_CYCLES(D)
   ) dut (
      .CLK100MHZ(clk), .ck_rst(rst_n), .i_btn(i_btn), .i_sw(i_sw),
      .o_btn(o_btn), .o_btn_press(o_btn_press), .o_btn_release(o_btn_release), .o_sw(o_sw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int press_seen[NB];
   int rel_seen[NB];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: a channel's level flips once the synchronized value has
   // differed from it for D+1 consecutive samples; the synchronizer is a 2-deep delay.
   logic [NCH-1:0]      m_s1, m_s2, m_lvl;
   int                  m_run[NCH];
   int                  nx_run[NCH];
   logic [NCH-1:0]      nx_lvl;
   logic [NB-1:0]       nx_pr, nx_rl;
   logic [2*NB+NCH-1:0] exp_q[$];

   always_comb begin
      nx_lvl = m_lvl;
      nx_pr  = '0;
      nx_rl  = '0;
      for (int i = 0; i < NCH; i++) begin
         nx_run[i] = 0;
         if (m_s2[i] != m_lvl[i]) begin
            if (m_run[i] + 1 == D + 1) nx_lvl[i] = m_s2[i];
            else nx_run[i] = m_run[i] + 1;
         end
      end
      for (int i = 0; i < NB; i++) begin
         nx_pr[i] = nx_lvl[i] & ~m_lvl[i];
         nx_rl[i] = ~nx_lvl[i] & m_lvl[i];
      end
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         m_s1  <= '0;
         m_s2  <= '0;
         m_lvl <= '0;
         for (int i = 0; i < NCH; i++) m_run[i] <= 0;
         exp_q.push_back('0);
      end else begin
         m_s1  <= {i_sw, i_btn};
         m_s2  <= m_s1;
         m_lvl <= nx_lvl;
         for (int i = 0; i < NCH; i++) m_run[i] <= nx_run[i];
         exp_q.push_back({nx_pr, nx_rl, nx_lvl});
      end
   end

   // Monitor
   initial begin
      for (int i = 0; i < NB; i++) begin
         press_seen[i] = 0;
         rel_seen[i]   = 0;
      end
   end

   always @(negedge clk) begin
      logic [2*NB+NCH-1:0] e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("o_btn_press",   32'(o_btn_press),   32'(e[15:12]));
         chk("o_btn_release", 32'(o_btn_release), 32'(e[11:8]));
         chk("o_sw",          32'(o_sw),          32'(e[7:4]));
         chk("o_btn",         32'(o_btn),         32'(e[3:0]));
         for (int i = 0; i < NB; i++) begin
            if (o_btn_press[i] === 1'b1)   press_seen[i]++;
            if (o_btn_release[i] === 1'b1) rel_seen[i]++;
         end
      end
   end

   // Stimulus changes one time unit after a falling edge.
   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Edge index (E0 = first edge after the input change) at which the pulse shows.
   task automatic measure(input int ch, input bit is_press, input int want, input string nm);
      int idx;
      idx = -1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if ((is_press ? o_btn_press[ch] : o_btn_release[ch]) === 1'b1) begin
            idx = k;
            break;
         end
      end
      chk(nm, 32'(idx), 32'(want));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int p0, r0;
      int hold;
      rst_n = 1'b0;
      i_btn = '0;
      i_sw  = '0;

      // Reset with random inputs, then release with inputs low
      for (int k = 0; k < 5; k++) begin
         wait_cyc(1);
         i_btn = NB'($urandom);
         i_sw  = NS'($urandom);
      end
      wait_cyc(1);
      i_btn = '0;
      i_sw  = '0;
      wait_cyc(1);
      rst_n = 1'b1;
      wait_cyc(50);
      chk("idle_outputs", 32'({o_btn, o_btn_press, o_btn_release, o_sw}), 32'd0);

      // Clean press / release on btn0
      i_btn[0] = 1'b1;
      measure(0, 1'b1, D + 2, "press_latency_btn0");
      chk("press_level_btn0", 32'(o_btn[0]), 32'd1);
      @(posedge clk); #1;
      chk("press_drop_btn0", 32'(o_btn_press[0]), 32'd0);
      wait_cyc(5);
      i_btn[0] = 1'b0;
      measure(0, 1'b0, D + 2, "release_latency_btn0");
      chk("release_level_btn0", 32'(o_btn[0]), 32'd0);
      @(posedge clk); #1;
      chk("release_drop_btn0", 32'(o_btn_release[0]), 32'd0);
      wait_cyc(5);

      // Bounce on btn1
      p0 = press_seen[1];
      r0 = rel_seen[1];
      for (int k = 0; k < 10; k++) begin
         i_btn[1] = ~k[0];
         wait_cyc(3);
      end
      i_btn[1] = 1'b1;
      wait_cyc(25);
      chk("bounce_press_count", 32'(press_seen[1] - p0), 32'd1);
      chk("bounce_release_count", 32'(rel_seen[1] - r0), 32'd0);

      // Glitch rejection on btn2
      p0 = press_seen[2];
      i_btn[2] = 1'b1;
      wait_cyc(D);
      i_btn[2] = 1'b0;
      wait_cyc(20);
      chk("short_press_ignored", 32'(press_seen[2] - p0), 32'd0);
      chk("short_press_level", 32'(o_btn[2]), 32'd0);
      i_btn[2] = 1'b1;
      wait_cyc(20);
      r0 = rel_seen[2];
      i_btn[2] = 1'b0;
      wait_cyc(D);
      i_btn[2] = 1'b1;
      wait_cyc(20);
      chk("short_gap_ignored", 32'(rel_seen[2] - r0), 32'd0);
      chk("short_gap_level", 32'(o_btn[2]), 32'd1);

      // Simultaneous events
      i_btn = '0;
      i_sw  = '0;
      wait_cyc(25);
      i_btn = 4'b1110;
      i_sw  = 4'hA;
      measure(3, 1'b1, D + 2, "simul_press_latency");
      chk("simul_press_vec", 32'(o_btn_press[3:1]), 32'd7);
      chk("simul_sw", 32'(o_sw), 32'hA);
      wait_cyc(5);

      // Reset mid-operation while btn0 is pressed
      i_btn = 4'b0001;
      i_sw  = '0;
      wait_cyc(25);
      chk("pre_reset_level", 32'(o_btn[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_reset_level", 32'({o_btn, o_sw}), 32'd0);
      chk("async_reset_release", 32'(o_btn_release), 32'd0);
      wait_cyc(4);
      rst_n = 1'b1;
      measure(0, 1'b1, D + 2, "post_reset_press_latency");
      wait_cyc(5);

      // Randomized holds on all channels
      for (int k = 0; k < 150; k++) begin
         i_btn = i_btn ^ (NB'($urandom) & NB'($urandom));
         i_sw  = i_sw ^ (NS'($urandom) & NS'($urandom));
         hold  = $urandom_range(1, 20);
         wait_cyc(hold);
      end
      i_btn = '0;
      i_sw  = '0;
      wait_cyc(25);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/btn_sw_conditioner.md
# btn_sw_conditioner

Input-side conditioner for the board's push buttons and slide switches. Each raw input is synchronized to CLK100MHZ and filtered by a per-channel debounce state machine. The block delivers clean levels for every button and switch, plus single-cycle press and release pulses per button. It sits between the board pins and the LED/selection logic, so downstream blocks need no edge-detect registers of their own.

## Interface
- NB_BTN, 4, number of button channels
- NB_SW, 4, number of switch channels
- NB_DEBOUNCE, 20, debounce counter width
- DEBOUNCE_CYCLES, 1000000, cycles the synchronized input must hold a new value (10 ms at 100 MHz); legal range 2 .. 2**NB_DEBOUNCE-1
- CLK100MHZ  input  1  system clock; all logic on the rising edge
- ck_rst  input  1  reset, asynchronous, active-low
- i_btn  input  NB_BTN  raw buttons, asynchronous, active-high
- i_sw  input  NB_SW  raw switches, asynchronous, active-high
- o_btn  output  NB_BTN  debounced button level
- o_btn_press  output  NB_BTN  one-cycle pulse on each debounced 0->1 of a button
- o_btn_release  output  NB_BTN  one-cycle pulse on each debounced 1->0 of a button
- o_sw  output  NB_SW  debounced switch level

## Operation
- Every channel (NB_BTN + NB_SW) is independent and identical. Switch channels produce only a level output.
- Synchronizer: two flops per channel, reset 0. s is the second flop's output.
- Each channel has an FSM with states RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND and a counter cnt[NB_DEBOUNCE-1:0].
  - RELEASED: if s=1, go to PRESS_PEND and set cnt=0.
  - PRESS_PEND:
    - if s=0, go to RELEASED with no pulse (bounce abort);
    - else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED and pulse press;
    - else cnt+1.
  - PRESSED: if s=0, go to RELEASE_PEND and set cnt=0.
  - RELEASE_PEND:
    - if s=1, go to PRESSED with no pulse;
    - else if cnt==DEBOUNCE_CYCLES-1, go to RELEASED and pulse release;
    - else cnt+1.
- Level output is 1 in PRESSED and RELEASE_PEND, 0 otherwise.
- All outputs are registered, with no combinational path from inputs to outputs.
- cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Simultaneous events on several channels give pulses in the same cycle, with no arbitration.
- press and release on one channel are never high in the same cycle.
- Reset mid-operation: all FSMs go to RELEASED, cnt=0, synchronizers clear, every output goes to 0 immediately, and no release pulse is generated.
- Input already high when reset deasserts: the channel treats it as a fresh press and pulses press after the normal latency.

## Timing
- Reset value of o_btn, o_btn_press, o_btn_release and o_sw: all 0.
- Let E0 be the first rising edge that samples a raw input high, with the input stable from then on. Latency:
  - synchronizer out at E1;
  - FSM enters PRESS_PEND at E2;
  - level and press pulse update at edge E(DEBOUNCE_CYCLES+2);
  - the press pulse is high for exactly one cycle.
- Release is symmetric: o_btn falls and o_btn_release pulses at E(DEBOUNCE_CYCLES+2) after the first low sample.
- Minimum accepted width: the synchronized input must be stable for DEBOUNCE_CYCLES+1 consecutive edges. Shorter pulses or gaps produce no output change.
- Maximum event rate per channel: one press per 2*(DEBOUNCE_CYCLES+1) cycles.

## Test plan
All scenarios use DEBOUNCE_CYCLES=8.
- Reset: hold ck_rst=0 with random i_btn/i_sw, then release with inputs 0 -> all outputs 0 for 50 cycles.
- Clean press/release on btn0:
  - i_btn[0] goes 1 at E0 -> o_btn[0]=1 and o_btn_press[0]=1 at E10; the pulse drops at E11.
  - Drop input at F0 -> o_btn[0]=0 and o_btn_release[0]=1 at F10, for one cycle.
- Bounce: i_btn[1] toggles every 3 cycles for 30 cycles, then holds high -> exactly one press pulse, 10 edges after the final rising sample, and no release pulse.
- Glitch rejection: i_btn[2] high for 8 cycles, then low -> o_btn[2] and both pulses stay 0. A glitch of 8 low cycles while pressed -> o_btn[2] stays 1.
- Simultaneous: i_btn[3:1]=3'b111 and i_sw=4'hA on the same edge -> o_btn_press[3:1]=3'b111 in one cycle at E10, and o_sw=4'hA at E10.
- Reset mid-operation:
  - Assert ck_rst=0 while btn0 is PRESSED -> o_btn[0] goes 0 asynchronously, with no release pulse.
  - Deassert with i_btn[0] held high -> press pulse 10 edges after the first sample.
